// File: rtl/bp_nonsynth_commit_driver.sv
// Commit/writeback stimulus source: turns retired-instruction records into decode, commit
// and int/fp writeback traffic at fixed cycle offsets for exercising the cosim checker.

module bp_nonsynth_commit_driver_wbq
    #(parameter int els_p        = 8
     ,parameter int data_width_p = 66
     )
     (input  logic                    clk_i
     ,input  logic                    reset_i
     ,input  logic [15:0]             cnt_i
     ,input  logic                    enq_v_i
     ,input  logic [4:0]              enq_addr_i
     ,input  logic [data_width_p-1:0] enq_data_i
     ,input  logic [15:0]             enq_stamp_i
     ,output logic                    full_o
     ,output logic                    w_v_o
     ,output logic [4:0]              w_addr_o
     ,output logic [data_width_p-1:0] w_data_o
     );

    localparam int ptr_width_lp = $clog2(els_p);

    logic [4:0]              addr_mem_q  [els_p];
    logic [data_width_p-1:0] data_mem_q  [els_p];
    logic [15:0]             stamp_mem_q [els_p];

    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp:0]   count_q, count_d;
    logic                    empty, enq, deq;
    logic [15:0]             age;

    assign empty  = (count_q == '0);
    assign full_o = (count_q == (ptr_width_lp+1)'(els_p));
    assign enq    = enq_v_i & ~full_o;
    // Signed age keeps the release test correct across the 16-bit counter wrap.
    assign age    = cnt_i - stamp_mem_q[rd_ptr_q];
    assign deq    = ~reset_i & ~empty & ~age[15];

    always_comb begin
        w_v_o    = deq;
        w_addr_o = '0;
        w_data_o = '0;
        if (deq) begin
            w_addr_o = addr_mem_q[rd_ptr_q];
            w_data_o = data_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
        if (deq) rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + (ptr_width_lp+1)'(1);
            2'b01:   count_d = count_q - (ptr_width_lp+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_mem_q[wr_ptr_q]  <= enq_addr_i;
            data_mem_q[wr_ptr_q]  <= enq_data_i;
            stamp_mem_q[wr_ptr_q] <= enq_stamp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

module bp_nonsynth_commit_driver
    #(parameter int vaddr_width_p  = 39
     ,parameter int dpath_width_p  = 66
     ,parameter int wb_delay_p     = 3
     ,parameter int els_p          = 8
     ,parameter int decode_width_p = 8
     ,parameter int commit_width_p = 80
     )
     (input  logic                      clk_i
     ,input  logic                      reset_i
     ,input  logic                      rec_v_i
     ,output logic                      rec_ready_o
     ,input  logic [vaddr_width_p-1:0]  rec_pc_i
     ,input  logic [31:0]               rec_instr_i
     ,input  logic [1:0]                rec_kind_i
     ,input  logic                      rec_late_i
     ,input  logic [dpath_width_p-1:0]  rec_data_i
     ,output logic [decode_width_p-1:0] decode_o
     ,output logic [commit_width_p-1:0] commit_pkt_o
     ,output logic                      ird_w_v_o
     ,output logic [4:0]                ird_addr_o
     ,output logic [dpath_width_p-1:0]  ird_data_o
     ,output logic                      frd_w_v_o
     ,output logic [4:0]                frd_addr_o
     ,output logic [dpath_width_p-1:0]  frd_data_o
     );

    typedef struct packed {
        logic                     v;
        logic [1:0]               kind;
        logic                     late;
        logic [vaddr_width_p-1:0] pc;
        logic [31:0]              instr;
    } stage_s;

    localparam logic [1:0]  kind_none_lp  = 2'd0;
    localparam logic [1:0]  kind_int_lp   = 2'd1;
    localparam logic [1:0]  kind_fp_lp    = 2'd2;
    localparam logic [1:0]  kind_trap_lp  = 2'd3;
    localparam logic [15:0] early_ofs_lp  = 16'd4;
    localparam logic [15:0] late_ofs_lp   = 16'(4 + wb_delay_p);

    logic [15:0]              cnt_q, cnt_d;
    stage_s                   dec_q, dec_d;
    stage_s                   c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [4:0]               rd_addr;
    logic [1:0]               kind_eff;
    logic                     accept;
    logic [15:0]              stamp;
    logic [dpath_width_p-1:0] int_data;
    logic                     iq_full, fq_full, iq_enq, fq_enq;

    assign rd_addr     = rec_instr_i[11:7];
    // Writes to x0 carry no architectural effect, so they travel as plain commits.
    assign kind_eff    = (rec_kind_i == kind_int_lp && rd_addr == 5'd0) ? kind_none_lp : rec_kind_i;
    assign rec_ready_o = ~reset_i & ~iq_full & ~fq_full;
    assign accept      = rec_v_i & rec_ready_o;
    assign iq_enq      = accept & (kind_eff == kind_int_lp);
    assign fq_enq      = accept & (kind_eff == kind_fp_lp);
    assign stamp       = cnt_q + (rec_late_i ? late_ofs_lp : early_ofs_lp);

    always_comb begin
        int_data       = '0;
        int_data[63:0] = rec_data_i[63:0];
    end

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        dec_d = '0;
        if (accept) begin
            dec_d.v     = 1'b1;
            dec_d.kind  = kind_eff;
            dec_d.late  = rec_late_i;
            dec_d.pc    = rec_pc_i;
            dec_d.instr = rec_instr_i;
        end
        c1_d = dec_q;
        c2_d = c1_q;
        c3_d = c2_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            dec_q <= '0;
            c1_q  <= '0;
            c2_q  <= '0;
            c3_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            dec_q <= dec_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
            c3_q  <= c3_d;
        end
    end

    // decode_o: [0] irf_w_v, [1] frf_w_v, [2] late_iwb_v, [3] late_fwb_v; all else 0.
    always_comb begin
        decode_o = '0;
        if (~reset_i & dec_q.v) begin
            decode_o[0] = (dec_q.kind == kind_int_lp) & ~dec_q.late;
            decode_o[1] = (dec_q.kind == kind_fp_lp)  & ~dec_q.late;
            decode_o[2] = (dec_q.kind == kind_int_lp) &  dec_q.late;
            decode_o[3] = (dec_q.kind == kind_fp_lp)  &  dec_q.late;
        end
    end

    // commit_pkt_o: [0] exception, [1] instret, [33:2] instr, pc from bit 34; all else 0.
    always_comb begin
        commit_pkt_o = '0;
        if (~reset_i & c3_q.v) begin
            commit_pkt_o[0]                   = (c3_q.kind == kind_trap_lp);
            commit_pkt_o[1]                   = (c3_q.kind != kind_trap_lp);
            commit_pkt_o[33:2]                = c3_q.instr;
            commit_pkt_o[34 +: vaddr_width_p] = c3_q.pc;
        end
    end

    bp_nonsynth_commit_driver_wbq
        #(.els_p(els_p), .data_width_p(dpath_width_p))
        int_wbq
        (.clk_i       (clk_i)
        ,.reset_i     (reset_i)
        ,.cnt_i       (cnt_q)
        ,.enq_v_i     (iq_enq)
        ,.enq_addr_i  (rd_addr)
        ,.enq_data_i  (int_data)
        ,.enq_stamp_i (stamp)
        ,.full_o      (iq_full)
        ,.w_v_o       (ird_w_v_o)
        ,.w_addr_o    (ird_addr_o)
        ,.w_data_o    (ird_data_o)
        );

    bp_nonsynth_commit_driver_wbq
        #(.els_p(els_p), .data_width_p(dpath_width_p))
        fp_wbq
        (.clk_i       (clk_i)
        ,.reset_i     (reset_i)
        ,.cnt_i       (cnt_q)
        ,.enq_v_i     (fq_enq)
        ,.enq_addr_i  (rd_addr)
        ,.enq_data_i  (rec_data_i)
        ,.enq_stamp_i (stamp)
        ,.full_o      (fq_full)
        ,.w_v_o       (frd_w_v_o)
        ,.w_addr_o    (frd_addr_o)
        ,.w_data_o    (frd_data_o)
        );

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// Directed bench: decode/commit/writeback timing, late ordering, traps, fp, queue full, wrap, reset.

module tb_bp_nonsynth_commit_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        rec_v, rec_v_b;
    logic [38:0] rec_pc;
    logic [31:0] rec_instr;
    logic [1:0]  rec_kind;
    logic        rec_late;
    logic [65:0] rec_data;

    logic        rdy, ird_v, frd_v;
    logic [7:0]  decode;
    logic [79:0] commit;
    logic [4:0]  ird_a, frd_a;
    logic [65:0] ird_d, frd_d;

    logic        rdy_b, ird_v_b, frd_v_b;
    logic [7:0]  decode_b;
    logic [79:0] commit_b;
    logic [4:0]  ird_a_b, frd_a_b;
    logic [65:0] ird_d_b, frd_d_b;

    int          checks = 0;
    int          failures = 0;
    logic [70:0] exp_q[$];
    logic [70:0] exp_e;
    int          idx, wb_n, drop_cyc, back_cyc, first_wb;
    logic [4:0]  brd;
    logic [65:0] bdata;

    bp_nonsynth_commit_driver #(.wb_delay_p(3)) dut
        (.clk_i(clk), .reset_i(reset), .rec_v_i(rec_v), .rec_ready_o(rdy)
        ,.rec_pc_i(rec_pc), .rec_instr_i(rec_instr), .rec_kind_i(rec_kind)
        ,.rec_late_i(rec_late), .rec_data_i(rec_data), .decode_o(decode)
        ,.commit_pkt_o(commit), .ird_w_v_o(ird_v), .ird_addr_o(ird_a), .ird_data_o(ird_d)
        ,.frd_w_v_o(frd_v), .frd_addr_o(frd_a), .frd_data_o(frd_d));

    // Long-delay instance so a one-per-cycle burst can actually fill a queue.
    bp_nonsynth_commit_driver #(.wb_delay_p(15)) dut_q
        (.clk_i(clk), .reset_i(reset), .rec_v_i(rec_v_b), .rec_ready_o(rdy_b)
        ,.rec_pc_i(rec_pc), .rec_instr_i(rec_instr), .rec_kind_i(rec_kind)
        ,.rec_late_i(rec_late), .rec_data_i(rec_data), .decode_o(decode_b)
        ,.commit_pkt_o(commit_b), .ird_w_v_o(ird_v_b), .ird_addr_o(ird_a_b), .ird_data_o(ird_d_b)
        ,.frd_w_v_o(frd_v_b), .frd_addr_o(frd_a_b), .frd_data_o(frd_d_b));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_iwb(input string tag, input logic v, input logic [4:0] a, input logic [65:0] d);
        chk({tag, "_v"}, ird_v, v);
        chk({tag, "_addr"}, ird_a, a);
        chk({tag, "_data"}, ird_d, d);
    endtask

    task automatic chk_fwb(input string tag, input logic v, input logic [4:0] a, input logic [65:0] d);
        chk({tag, "_v"}, frd_v, v);
        chk({tag, "_addr"}, frd_a, a);
        chk({tag, "_data"}, frd_d, d);
    endtask

    function automatic logic [79:0] mk_commit(input logic [38:0] pc, input logic [31:0] instr,
                                              input logic trap);
        logic [79:0] p;
        p        = '0;
        p[0]     = trap;
        p[1]     = ~trap;
        p[33:2]  = instr;
        p[72:34] = pc;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        rec_v     = 1'b0;
        rec_v_b   = 1'b0;
        rec_pc    = '0;
        rec_instr = '0;
        rec_kind  = '0;
        rec_late  = 1'b0;
        rec_data  = '0;
    endtask

    task automatic drive(input logic [38:0] pc, input logic [31:0] instr, input logic [1:0] kind,
                         input logic late, input logic [65:0] data);
        rec_v     = 1'b1;
        rec_pc    = pc;
        rec_instr = instr;
        rec_kind  = kind;
        rec_late  = late;
        rec_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        adv(3);
        settle();
        chk("rst_ready", rdy, 1'b0);
        chk("rst_ready_b", rdy_b, 1'b0);
        chk("rst_decode", decode, 8'h0);
        chk("rst_commit", commit, 80'h0);
        chk_iwb("rst_iwb", 1'b0, 5'd0, 66'h0);
        chk_fwb("rst_fwb", 1'b0, 5'd0, 66'h0);
        tick();
        reset = 1'b0;
        adv(10);

        // early int write x5 = 5
        drive(39'h80000000, 32'h00500293, 2'd1, 1'b0, 66'h5);
        settle(); chk("t1_ready", rdy, 1'b1);
        tick(); idle(); settle();
        chk("t1_decode", decode, 8'h01);
        chk_iwb("t1_iwb_early", 1'b0, 5'd0, 66'h0);
        adv(2); settle();
        chk("t1_commit_early", commit, 80'h0);
        tick(); settle();
        chk("t1_commit", commit, mk_commit(39'h80000000, 32'h00500293, 1'b0));
        chk_iwb("t1_iwb", 1'b1, 5'd5, 66'h5);
        chk("t1_fwb_idle", frd_v, 1'b0);
        tick(); settle();
        chk("t1_commit_after", commit, 80'h0);
        chk_iwb("t1_iwb_after", 1'b0, 5'd0, 66'h0);

        // late x6 then early x7 behind it
        tick();
        drive(39'h80000004, 32'h00A00313, 2'd1, 1'b1, 66'hABCD);
        settle();
        tick();
        drive(39'h80000008, 32'h00100393, 2'd1, 1'b0, 66'h77);
        settle(); chk("t2_decode_late", decode, 8'h04);
        tick(); idle(); settle();
        chk("t2_decode_early", decode, 8'h01);
        adv(2); settle();
        chk("t2_commit_x6", commit, mk_commit(39'h80000004, 32'h00A00313, 1'b0));
        chk_iwb("t2_iwb_t4", 1'b0, 5'd0, 66'h0);
        tick(); settle();
        chk("t2_commit_x7", commit, mk_commit(39'h80000008, 32'h00100393, 1'b0));
        chk_iwb("t2_iwb_t5_blocked", 1'b0, 5'd0, 66'h0);
        adv(2); settle();
        chk_iwb("t2_iwb_x6", 1'b1, 5'd6, 66'hABCD);
        tick(); settle();
        chk_iwb("t2_iwb_x7", 1'b1, 5'd7, 66'h77);
        tick(); settle();
        chk_iwb("t2_iwb_done", 1'b0, 5'd0, 66'h0);

        // trap: exception commit, no writeback
        tick();
        drive(39'h80000010, 32'h00000073, 2'd3, 1'b1, 66'h1234);
        settle();
        tick(); idle(); settle();
        chk("t3_decode", decode, 8'h0);
        adv(3); settle();
        chk("t3_commit", commit, mk_commit(39'h80000010, 32'h00000073, 1'b1));
        chk_iwb("t3_iwb_t4", 1'b0, 5'd0, 66'h0);
        chk("t3_fwb_t4", frd_v, 1'b0);
        adv(3); settle();
        chk_iwb("t3_iwb_t7", 1'b0, 5'd0, 66'h0);
        chk("t3_fwb_t7", frd_v, 1'b0);

        // early fp f3
        tick();
        drive(39'h80000020, 32'h00000187, 2'd2, 1'b0, 66'h3F800000);
        settle();
        tick(); idle(); settle();
        chk("t4_decode", decode, 8'h02);
        adv(3); settle();
        chk("t4_commit", commit, mk_commit(39'h80000020, 32'h00000187, 1'b0));
        chk_fwb("t4_fwb", 1'b1, 5'd3, 66'h3F800000);
        chk("t4_iwb_idle", ird_v, 1'b0);
        tick(); settle();
        chk_fwb("t4_fwb_after", 1'b0, 5'd0, 66'h0);

        // late fp f4 keeps all 66 bits
        tick();
        drive(39'h80000024, 32'h00000207, 2'd2, 1'b1, 66'h3_0000_0000_0000_0001);
        settle();
        tick(); idle(); settle();
        chk("t4b_decode", decode, 8'h08);
        adv(3); settle();
        chk("t4b_fwb_t4", frd_v, 1'b0);
        adv(3); settle();
        chk_fwb("t4b_fwb", 1'b1, 5'd4, 66'h3_0000_0000_0000_0001);

        // int write to x0 becomes a plain commit
        tick();
        drive(39'h80000028, 32'h00000013, 2'd1, 1'b0, 66'hFF);
        settle();
        tick(); idle(); settle();
        chk("t4c_decode", decode, 8'h0);
        adv(3); settle();
        chk("t4c_commit", commit, mk_commit(39'h80000028, 32'h00000013, 1'b0));
        chk_iwb("t4c_iwb", 1'b0, 5'd0, 66'h0);

        // int writeback carries only the low 64 bits
        tick();
        drive(39'h8000002C, 32'h00000093, 2'd1, 1'b0, 66'h3_FFFF_FFFF_FFFF_FFFF);
        settle();
        tick(); idle(); settle();
        adv(3); settle();
        chk_iwb("t4d_iwb", 1'b1, 5'd1, 66'h0_FFFF_FFFF_FFFF_FFFF);

        // 20 back-to-back late int records into the long-delay instance
        tick();
        idx = 0; wb_n = 0; drop_cyc = -1; back_cyc = -1; first_wb = -1;
        for (int c = 0; c < 120; c++) begin
            if (idx < 20) begin
                brd       = 5'(idx + 1);
                bdata     = 66'h100 + 66'(idx);
                rec_v_b   = 1'b1;
                rec_pc    = 39'h80001000 + 39'(idx * 4);
                rec_instr = 32'h00000013 | (32'(brd) << 7);
                rec_kind  = 2'd1;
                rec_late  = 1'b1;
                rec_data  = bdata;
            end else begin
                rec_v_b = 1'b0;
            end
            settle();
            if (ird_v_b) begin
                if (first_wb < 0) first_wb = c;
                if (exp_q.size() == 0) begin
                    chk("burst_unexpected_wb", ird_v_b, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("burst_wb_addr", ird_a_b, exp_e[70:66]);
                    chk("burst_wb_data", ird_d_b, exp_e[65:0]);
                end
                wb_n++;
            end
            if (rec_v_b && rdy_b) begin
                exp_q.push_back({brd, bdata});
                idx++;
            end
            if (!rdy_b && drop_cyc < 0) drop_cyc = c;
            if (rdy_b && drop_cyc >= 0 && back_cyc < 0) back_cyc = c;
            tick();
        end
        idle();
        settle();
        chk("burst_ready_drop_cycle", drop_cyc, 8);
        chk("burst_ready_back_cycle", back_cyc, 20);
        chk("burst_first_wb_cycle", first_wb, 19);
        chk("burst_accepted", idx, 20);
        chk("burst_wb_count", wb_n, 20);
        chk("burst_queue_left", exp_q.size(), 0);
        chk("burst_idle_decode", decode_b, 8'h0);
        chk("burst_idle_commit", commit_b, 80'h0);
        chk("burst_idle_fwb_v", frd_v_b, 1'b0);
        chk("burst_idle_fwb_addr", frd_a_b, 5'd0);
        chk("burst_idle_fwb_data", frd_d_b, 66'h0);

        // counter wrap: first record accepted at cnt = 0xFFFD
        reset = 1'b1;
        tick();
        reset = 1'b0;
        adv(65533);
        drive(39'h80002000, 32'h00000413, 2'd1, 1'b1, 66'h8888);
        settle(); chk("wrap_ready", rdy, 1'b1);
        tick();
        drive(39'h80002004, 32'h00000493, 2'd1, 1'b0, 66'h9999);
        settle(); chk_iwb("wrap_t1", 1'b0, 5'd0, 66'h0);
        tick();
        drive(39'h80002008, 32'h00000513, 2'd1, 1'b1, 66'hAAAA);
        settle(); chk_iwb("wrap_t2", 1'b0, 5'd0, 66'h0);
        tick(); idle(); settle();
        chk_iwb("wrap_t3", 1'b0, 5'd0, 66'h0);
        tick(); settle();
        chk("wrap_commit_x8", commit, mk_commit(39'h80002000, 32'h00000413, 1'b0));
        chk_iwb("wrap_t4", 1'b0, 5'd0, 66'h0);
        adv(2); settle();
        chk_iwb("wrap_t6", 1'b0, 5'd0, 66'h0);
        tick(); settle();
        chk_iwb("wrap_x8", 1'b1, 5'd8, 66'h8888);
        tick(); settle();
        chk_iwb("wrap_x9", 1'b1, 5'd9, 66'h9999);
        tick(); settle();
        chk_iwb("wrap_x10", 1'b1, 5'd10, 66'hAAAA);
        tick(); settle();
        chk_iwb("wrap_done", 1'b0, 5'd0, 66'h0);

        // reset with writebacks pending
        tick();
        drive(39'h80003000, 32'h00000593, 2'd1, 1'b1, 66'hB);
        settle();
        tick();
        drive(39'h80003004, 32'h00000613, 2'd1, 1'b0, 66'hC);
        settle();
        tick(); idle(); reset = 1'b1; settle();
        chk("mid_rst_ready", rdy, 1'b0);
        chk("mid_rst_decode", decode, 8'h0);
        chk_iwb("mid_rst_iwb", 1'b0, 5'd0, 66'h0);
        tick(); reset = 1'b0; settle();
        chk("mid_rst_ready_after", rdy, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick(); settle();
            chk("post_rst_iwb_v", ird_v, 1'b0);
            chk("post_rst_commit", commit, 80'h0);
            chk("post_rst_decode", decode, 8'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_commit_driver.md
# bp_nonsynth_commit_driver

Non-synthesizable stimulus source for the commit/writeback side of the cosimulation interface. It accepts a stream of retired-instruction records from a testbench and emits a decode vector, commit packets and integer/FP register writebacks on the exact cycle relationships the cosim checker consumes: decode 3 cycles ahead of commit, and writebacks either at commit or late by a fixed delay. It lets checker, trace and FIFO logic be exercised without a full BE pipeline.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies vaddr_width_p, dpath_width_gp and struct widths
- wb_delay_p, 3: extra cycles a late writeback trails its commit; legal range 1..15
- els_p, 8: depth of each writeback queue (int, fp); power of 2
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- rec_v_i  in  1  record valid
- rec_ready_o  out  1  record accepted when rec_v_i & rec_ready_o
- rec_pc_i  in  vaddr_width_p  record PC
- rec_instr_i  in  32  instruction; rd_addr taken from bits [11:7]
- rec_kind_i  in  2  0 none, 1 int write, 2 fp write, 3 trap
- rec_late_i  in  1  writeback is late (late_iwb_v/late_fwb_v) vs at commit
- rec_data_i  in  dpath_width_gp  writeback value (int uses low 64 bits)
- decode_o  out  $bits(bp_be_decode_s)  only irf_w_v, frf_w_v, late_iwb_v, late_fwb_v driven; all other fields 0
- commit_pkt_o  out  bp_be_commit_pkt width  pc, instr, instret, exception driven; others 0
- ird_w_v_o / ird_addr_o / ird_data_o  out  1 / 5 / dpath_width_gp  int writeback
- frd_w_v_o / frd_addr_o / frd_data_o  out  1 / 5 / dpath_width_gp  fp writeback

## Operation
- Accept at cycle t. Kind 1 with rd_addr 0 is downgraded to kind 0.
- Decode: registered; decode_o valid in cycle t+1 only, then returns to 0. Kind 1: irf_w_v=~late, late_iwb_v=late; kind 2: same on fp fields; kinds 0/3: all 0.
- Commit: 3-stage shift register behind decode stage; commit_pkt_o in cycle t+4 with pc, instr, instret=(kind!=3), exception=(kind==3). Zero in cycles with no record.
- Writeback queues: one per file, in-order FIFO of {rd_addr, data, stamp}. Entry enqueued at t with stamp = cnt+4 (early) or cnt+4+wb_delay_p (late), cnt = 16-bit free-running cycle counter.
- Head released (w_v_o=1, addr/data from head, dequeued) when (cnt - stamp) interpreted as signed 16-bit is >= 0. Max one release per file per cycle. Later early writes wait behind an earlier late write to preserve per-register order.
- rec_ready_o = ~reset_i & int queue not full & fp queue not full (registered-free, combinational from counts). Simultaneous enqueue and dequeue on a full queue is not allowed to accept.
- Traps produce no writeback and no queue entry.

## Timing
- Reset: all outputs 0, rec_ready_o 0 while reset_i high, queues empty, shift register cleared, cnt=0. Reset mid-operation discards in-flight records and pending writebacks with no further output.
- Throughput: one record per cycle while not full.
- Early writeback appears the same cycle as its commit_pkt (t+4); late at t+4+wb_delay_p, or later if blocked behind older queue entries.
- Counter wrap at 2^16 handled by signed difference; stamps never exceed 2^15 ahead.
- Idle input: decode_o and commit_pkt_o zero; queues drain independently.

## Test plan
- Reset then record pc=0x80000000, instr=0x00500293 (addi x5), kind 1, late 0, data 5 at t=10 -> decode_o.irf_w_v in 11, commit instret pc=0x80000000 in 14, ird_w_v_o x5=5 in 14.
- Late int write x6=0xABCD at t=10, wb_delay_p=3 -> late_iwb_v in 11, commit in 14, ird_w_v_o x6 in 17; early x7 accepted t=11 writes in 18 (not 15).
- Kind 3 trap at t=20 -> commit exception=1 instret=0 in 24, no writeback, decode_o zero.
- Fp write f3 data 0x3F80_0000 (rec format) kind 2 early -> frd_w_v_o f3 same cycle as commit; int port idle.
- 20 back-to-back late int records -> rec_ready_o drops after 8 pending, writebacks emerge one per cycle in accept order, no loss.
- Run past cnt 0xFFFF with late writes across wrap; also assert reset_i during pending writes -> no writeback after reset.
